// File: rtl/mem_acc_ldst_pkg.sv
// Shared types and default sizing for the load/store responder in the PE memory access controller.
// Pure declarations: no logic, no latency, no flow control.
package mem_acc_ldst_pkg;

    localparam int DEF_ADDR_W         = 16;
    localparam int DEF_DATA_W         = 64;
    localparam int DEF_MEM_RD_LATENCY = 2;
    localparam int DEF_RDQ_DEPTH      = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        DRAIN   = 2'd2
    } ldst_state_e;

    // Counter width able to hold the value depth itself (0..depth inclusive).
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ldst_rd_fifo.sv
// Read-return buffer: synchronous DEPTH x DATA_W FIFO with occupancy count.
// Latency: a pushed word is visible on pop_dat the cycle after the push.
// Backpressure: push is ignored when full, pop is ignored when empty; the owner keeps both from happening.
module ldst_rd_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64
) (
    input  logic                         clk,
    input  logic                         reset_poweron,
    input  logic                         push_vld,
    input  logic [DATA_W-1:0]            push_dat,
    input  logic                         pop_vld,
    output logic [DATA_W-1:0]            pop_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];
    assign do_push = push_vld && !full;
    assign do_pop  = pop_vld && !empty;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/mem_acc_ldst_resp.sv
// Memory-side responder for the SIMD load/store port: bank ownership vs DMA, SRAM issue, read return.
// Latency: accepted beat drives SRAM 1 cycle later; read data valid MEM_RD_LATENCY+2 cycles after accept.
// Backpressure: read credits bound reads in flight to RDQ_DEPTH; read_pause holds the output register.
module mem_acc_ldst_resp
    import mem_acc_ldst_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int MEM_RD_LATENCY = DEF_MEM_RD_LATENCY,
    parameter int RDQ_DEPTH      = DEF_RDQ_DEPTH
) (
    input  logic              clk,
    input  logic              reset_poweron,
    input  logic              ldst__memc__request,
    output logic              memc__ldst__granted,
    input  logic              ldst__memc__released,
    input  logic              ldst__memc__write_valid,
    input  logic [ADDR_W-1:0] ldst__memc__write_address,
    input  logic [DATA_W-1:0] ldst__memc__write_data,
    output logic              memc__ldst__write_ready,
    input  logic              ldst__memc__read_valid,
    input  logic [ADDR_W-1:0] ldst__memc__read_address,
    output logic              memc__ldst__read_ready,
    output logic [DATA_W-1:0] memc__ldst__read_data,
    output logic              memc__ldst__read_data_valid,
    input  logic              ldst__memc__read_pause,
    input  logic              dma__ldst__active,
    output logic              memc__sram__wen,
    output logic              memc__sram__ren,
    output logic [ADDR_W-1:0] memc__sram__addr,
    output logic [DATA_W-1:0] memc__sram__wdata,
    input  logic [DATA_W-1:0] sram__memc__rdata
);
    localparam int CNT_W = credit_width(RDQ_DEPTH);
    localparam int SUM_W = CNT_W + 1;

    ldst_state_e                state_q, state_d;
    logic                       granted_q, granted_d;
    logic                       wen_q, wen_d;
    logic                       ren_q, ren_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic [DATA_W-1:0]          wdata_q, wdata_d;
    logic [CNT_W-1:0]           outstanding_q, outstanding_d;
    logic [MEM_RD_LATENCY-1:0]  ren_pipe_q, ren_pipe_d;
    logic                       out_vld_q, out_vld_d;
    logic [DATA_W-1:0]          out_dat_q, out_dat_d;

    logic                       in_grant;
    logic                       wr_acc, rd_acc;
    logic [SUM_W-1:0]           credit_used;
    logic                       tail;
    logic                       out_free;
    logic                       drained;
    logic                       fifo_push, fifo_pop;
    logic [DATA_W-1:0]          fifo_pop_dat;
    logic [CNT_W-1:0]           fifo_count;
    logic                       fifo_empty, fifo_full;

    assign in_grant = (state_q == GRANTED);

    // A read holds one credit from acceptance until the consumer takes it off the output register.
    assign credit_used = SUM_W'(outstanding_q) + SUM_W'(fifo_count) + SUM_W'(out_vld_q);

    assign memc__ldst__write_ready = in_grant;
    assign memc__ldst__read_ready  = in_grant && !ldst__memc__write_valid &&
                                     (credit_used < SUM_W'(RDQ_DEPTH));

    assign wr_acc = ldst__memc__write_valid && memc__ldst__write_ready;
    assign rd_acc = ldst__memc__read_valid && memc__ldst__read_ready;

    assign tail     = ren_pipe_q[MEM_RD_LATENCY-1];
    assign out_free = !out_vld_q || !ldst__memc__read_pause;
    assign drained  = (outstanding_q == '0) && fifo_empty && !out_vld_q;

    // Returning data skips the FIFO only when nothing older is queued ahead of it.
    assign fifo_pop  = out_free && !fifo_empty;
    assign fifo_push = tail && !(out_free && fifo_empty) && !fifo_full;

    always_comb begin
        state_d   = state_q;
        granted_d = granted_q;
        case (state_q)
            IDLE: begin
                if (ldst__memc__request && !dma__ldst__active) begin
                    state_d   = GRANTED;
                    granted_d = 1'b1;
                end
            end
            GRANTED: begin
                if (ldst__memc__released) begin
                    state_d   = DRAIN;
                    granted_d = 1'b0;
                end
            end
            DRAIN: begin
                if (drained) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                granted_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        wen_d   = wr_acc;
        ren_d   = rd_acc;
        addr_d  = '0;
        wdata_d = '0;
        if (wr_acc) begin
            addr_d  = ldst__memc__write_address;
            wdata_d = ldst__memc__write_data;
        end else if (rd_acc) begin
            addr_d  = ldst__memc__read_address;
        end
    end

    // Credits are taken at acceptance so the window before ren is already covered.
    always_comb begin
        ren_pipe_d    = '0;
        ren_pipe_d[0] = ren_q;
        for (int i = 1; i < MEM_RD_LATENCY; i++) begin
            ren_pipe_d[i] = ren_pipe_q[i-1];
        end
        outstanding_d = outstanding_q + CNT_W'(rd_acc) - CNT_W'(tail);
    end

    always_comb begin
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        if (out_free) begin
            if (!fifo_empty) begin
                out_vld_d = 1'b1;
                out_dat_d = fifo_pop_dat;
            end else if (tail) begin
                out_vld_d = 1'b1;
                out_dat_d = sram__memc__rdata;
            end else begin
                out_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            state_q       <= IDLE;
            granted_q     <= 1'b0;
            wen_q         <= 1'b0;
            ren_q         <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            outstanding_q <= '0;
            ren_pipe_q    <= '0;
            out_vld_q     <= 1'b0;
            out_dat_q     <= '0;
        end else begin
            state_q       <= state_d;
            granted_q     <= granted_d;
            wen_q         <= wen_d;
            ren_q         <= ren_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            outstanding_q <= outstanding_d;
            ren_pipe_q    <= ren_pipe_d;
            out_vld_q     <= out_vld_d;
            out_dat_q     <= out_dat_d;
        end
    end

    ldst_rd_fifo #(
        .DEPTH  (RDQ_DEPTH),
        .DATA_W (DATA_W)
    ) u_rd_fifo (
        .clk           (clk),
        .reset_poweron (reset_poweron),
        .push_vld      (fifo_push),
        .push_dat      (sram__memc__rdata),
        .pop_vld       (fifo_pop),
        .pop_dat       (fifo_pop_dat),
        .count         (fifo_count),
        .empty         (fifo_empty),
        .full          (fifo_full)
    );

    assign memc__ldst__granted         = granted_q;
    assign memc__sram__wen             = wen_q;
    assign memc__sram__ren             = ren_q;
    assign memc__sram__addr            = addr_q;
    assign memc__sram__wdata           = wdata_q;
    assign memc__ldst__read_data_valid = out_vld_q;
    assign memc__ldst__read_data       = out_dat_q;

endmodule

// File: tb/tb_mem_acc_ldst_resp.sv
// Bench for mem_acc_ldst_resp: SRAM model, shadow-memory reference and per-feature scenario tasks.
module tb_mem_acc_ldst_resp;
    localparam int AW = 16;
    localparam int DW = 64;
    localparam int L  = 2;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req, granted, released;
    logic          wvld, wrdy, rvld, rrdy, rdvld, pause, dma;
    logic [AW-1:0] waddr, raddr, s_addr;
    logic [DW-1:0] wdata, rdata_o, s_wdata, s_rdata;
    logic          s_wen, s_ren;

    int n_checks = 0;
    int n_pass   = 0;
    int n_rd_acc = 0;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] rcv_q [$];
    logic [DW-1:0] shadow   [0:255];
    logic [DW-1:0] sram_mem [0:255];
    logic [DW-1:0] rd_pipe  [0:L-1];

    always #5 clk = ~clk;

    mem_acc_ldst_resp #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_RD_LATENCY(L), .RDQ_DEPTH(D)
    ) dut (
        .clk                         (clk),
        .reset_poweron               (rst),
        .ldst__memc__request         (req),
        .memc__ldst__granted         (granted),
        .ldst__memc__released        (released),
        .ldst__memc__write_valid     (wvld),
        .ldst__memc__write_address   (waddr),
        .ldst__memc__write_data      (wdata),
        .memc__ldst__write_ready     (wrdy),
        .ldst__memc__read_valid      (rvld),
        .ldst__memc__read_address    (raddr),
        .memc__ldst__read_ready      (rrdy),
        .memc__ldst__read_data       (rdata_o),
        .memc__ldst__read_data_valid (rdvld),
        .ldst__memc__read_pause      (pause),
        .dma__ldst__active           (dma),
        .memc__sram__wen             (s_wen),
        .memc__sram__ren             (s_ren),
        .memc__sram__addr            (s_addr),
        .memc__sram__wdata           (s_wdata),
        .sram__memc__rdata           (s_rdata)
    );

    function automatic logic [DW-1:0] init_val(input int a);
        return {a[15:0], ~a[15:0], a[15:0] ^ 16'h5a5a, 16'hc0de};
    endfunction

    // SRAM bank: rdata for a read issued in cycle c is presented during cycle c+L.
    always @(posedge clk) begin
        if (s_wen) sram_mem[s_addr[7:0]] <= s_wdata;
        rd_pipe[0] <= s_ren ? sram_mem[s_addr[7:0]] : '0;
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign s_rdata = rd_pipe[L-1];

    // Reference: each accepted read returns the last accepted write to that address, in acceptance order.
    always @(negedge clk) begin
        if (!rst) begin
            if (wvld && wrdy) shadow[waddr[7:0]] = wdata;
            if (rvld && rrdy) begin
                exp_q.push_back(shadow[raddr[7:0]]);
                n_rd_acc++;
            end
            if (rdvld && !pause) rcv_q.push_back(rdata_o);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk); #1;
    endtask

    task automatic idle_inputs();
        req = 0; released = 0; wvld = 0; waddr = '0; wdata = '0;
        rvld = 0; raddr = '0; pause = 0; dma = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        repeat (3) tick();
        smp();
        n_checks++; if (granted !== 1'b0) $display("FAIL reset_granted: got %0b want 0", granted); else n_pass++;
        n_checks++; if ({wrdy, rrdy} !== 2'b00) $display("FAIL reset_readys: got %b want 00", {wrdy, rrdy}); else n_pass++;
        n_checks++; if ({s_wen, s_ren} !== 2'b00) $display("FAIL reset_sram_en: got %b want 00", {s_wen, s_ren}); else n_pass++;
        n_checks++; if (rdvld !== 1'b0) $display("FAIL reset_rdvld: got %0b want 0", rdvld); else n_pass++;
        n_checks++; if (rdata_o !== '0 || s_addr !== '0 || s_wdata !== '0)
            $display("FAIL reset_data: got rdata %h addr %h wdata %h want 0", rdata_o, s_addr, s_wdata); else n_pass++;
        tick(); rst = 0;
    endtask

    task automatic test_grant();
        int bad;
        req = 1; smp();
        n_checks++; if (granted !== 1'b0) $display("FAIL grant_same_cycle: got %0b want 0", granted); else n_pass++;
        tick(); smp();
        n_checks++; if (granted !== 1'b1) $display("FAIL grant_latency: got %0b want 1", granted); else n_pass++;
        tick(); req = 0; released = 1; smp();
        tick(); released = 0; smp();
        n_checks++; if (granted !== 1'b0) $display("FAIL release_drop: got %0b want 0", granted); else n_pass++;
        tick();
        dma = 1; req = 1; bad = 0;
        repeat (4) begin smp(); if (granted !== 1'b0) bad++; tick(); end
        n_checks++; if (bad != 0) $display("FAIL dma_block: got %0d granted cycles want 0", bad); else n_pass++;
        dma = 0; smp();
        n_checks++; if (granted !== 1'b0) $display("FAIL dma_drop_cycle: got %0b want 0", granted); else n_pass++;
        tick(); smp();
        n_checks++; if (granted !== 1'b1) $display("FAIL grant_after_dma: got %0b want 1", granted); else n_pass++;
        tick(); req = 0;
    endtask

    task automatic test_write_read();
        logic early;
        wvld = 1; waddr = 16'h0010; wdata = 64'hDEADBEEF_01234567; smp();
        n_checks++; if (wrdy !== 1'b1) $display("FAIL write_ready: got %0b want 1", wrdy); else n_pass++;
        tick(); wvld = 0; rvld = 1; raddr = 16'h0010; smp();
        n_checks++; if ({s_wen, s_addr, s_wdata} !== {1'b1, 16'h0010, 64'hDEADBEEF_01234567})
            $display("FAIL write_issue: got wen %0b addr %h wdata %h want 1 0010 deadbeef01234567", s_wen, s_addr, s_wdata); else n_pass++;
        n_checks++; if (rrdy !== 1'b1) $display("FAIL read_accept: got %0b want 1", rrdy); else n_pass++;
        tick(); rvld = 0; smp();
        n_checks++; if ({s_ren, s_wen, s_addr} !== {1'b1, 1'b0, 16'h0010})
            $display("FAIL read_issue: got ren %0b wen %0b addr %h want 1 0 0010", s_ren, s_wen, s_addr); else n_pass++;
        tick(); smp(); early = rdvld;
        tick(); smp(); early = early | rdvld;
        n_checks++; if (early !== 1'b0) $display("FAIL read_not_early: got %0b want 0", early); else n_pass++;
        tick(); smp();
        n_checks++; if (rdvld !== 1'b1 || rdata_o !== 64'hDEADBEEF_01234567)
            $display("FAIL read_latency_data: got vld %0b data %h want 1 deadbeef01234567", rdvld, rdata_o); else n_pass++;
        tick(); exp_q.delete(); rcv_q.delete();
    endtask

    task automatic test_pause_backpressure();
        int base, bad, cnt, mis;
        logic [DW-1:0] held;
        for (int i = 0; i < 8; i++) begin
            wvld = 1; waddr = AW'(16'h0100 + i); wdata = {$urandom(), $urandom()}; tick();
        end
        wvld = 0; exp_q.delete(); rcv_q.delete();
        base = n_rd_acc; pause = 1;
        repeat (12) begin rvld = 1; raddr = AW'(16'h0100 + (n_rd_acc - base)); tick(); end
        smp();
        n_checks++; if (n_rd_acc - base != 4) $display("FAIL pause_credit_limit: got %0d accepted want 4", n_rd_acc - base); else n_pass++;
        n_checks++; if (rrdy !== 1'b0) $display("FAIL pause_ready_low: got %0b want 0", rrdy); else n_pass++;
        n_checks++; if (rdvld !== 1'b1) $display("FAIL pause_head_valid: got %0b want 1", rdvld); else n_pass++;
        held = rdata_o; bad = 0;
        repeat (4) begin tick(); smp(); if (rdvld !== 1'b1 || rdata_o !== held) bad++; end
        n_checks++; if (bad != 0 || rcv_q.size() != 0)
            $display("FAIL pause_hold_stable: got %0d unstable cycles %0d consumed want 0 0", bad, rcv_q.size()); else n_pass++;
        tick(); pause = 0; cnt = 0;
        while ((n_rd_acc - base) < 8 && cnt < 40) begin raddr = AW'(16'h0100 + (n_rd_acc - base)); tick(); cnt++; end
        rvld = 0; cnt = 0;
        while (rcv_q.size() < 8 && cnt < 40) begin tick(); cnt++; end
        n_checks++; if (rcv_q.size() != 8 || exp_q.size() != 8)
            $display("FAIL pause_all_delivered: got %0d beats (%0d accepted) want 8", rcv_q.size(), exp_q.size()); else n_pass++;
        mis = 0;
        for (int i = 0; i < 8; i++) if (i < rcv_q.size() && i < exp_q.size() && rcv_q[i] !== exp_q[i]) mis++;
        n_checks++; if (mis != 0) $display("FAIL pause_order: got %0d mismatched beats want 0", mis); else n_pass++;
        exp_q.delete(); rcv_q.delete();
    endtask

    task automatic test_wr_rd_priority();
        logic [DW-1:0] wd;
        int cnt;
        wd = {$urandom(), $urandom()};
        wvld = 1; waddr = 16'h0020; wdata = wd; rvld = 1; raddr = 16'h0020; smp();
        n_checks++; if ({wrdy, rrdy} !== 2'b10) $display("FAIL wr_wins: got wrdy/rrdy %b want 10", {wrdy, rrdy}); else n_pass++;
        tick(); wvld = 0; smp();
        n_checks++; if (rrdy !== 1'b1) $display("FAIL rd_next_cycle: got %0b want 1", rrdy); else n_pass++;
        tick(); rvld = 0; cnt = 0;
        while (rcv_q.size() < 1 && cnt < 20) begin tick(); cnt++; end
        n_checks++; if (rcv_q.size() != 1 || rcv_q[0] !== wd)
            $display("FAIL raw_same_addr: got %0d beats first %h want 1 %h", rcv_q.size(), (rcv_q.size() > 0) ? rcv_q[0] : '0, wd); else n_pass++;
        exp_q.delete(); rcv_q.delete();
    endtask

    task automatic test_release_drain();
        int base, bad, cnt, mis;
        pause = 1; base = n_rd_acc; exp_q.delete(); rcv_q.delete();
        for (int k = 0; k < 3; k++) begin
            rvld = 1; raddr = AW'(16'h0100 + k);
            if (k == 2) begin released = 1; req = 1; end
            tick();
        end
        released = 0; smp();
        n_checks++; if (n_rd_acc - base != 3) $display("FAIL release_beat_completes: got %0d accepted want 3", n_rd_acc - base); else n_pass++;
        n_checks++; if ({granted, rrdy, wrdy} !== 3'b000) $display("FAIL drain_no_grant: got %b want 000", {granted, rrdy, wrdy}); else n_pass++;
        tick(); rvld = 0; bad = 0;
        repeat (4) begin smp(); if (granted !== 1'b0) bad++; tick(); end
        n_checks++; if (bad != 0) $display("FAIL drain_ignores_request: got %0d granted cycles want 0", bad); else n_pass++;
        pause = 0; cnt = 0;
        while (rcv_q.size() < 3 && cnt < 30) begin tick(); cnt++; end
        mis = 0;
        for (int i = 0; i < 3; i++) if (i < rcv_q.size() && i < exp_q.size() && rcv_q[i] !== exp_q[i]) mis++;
        n_checks++; if (rcv_q.size() != 3 || mis != 0)
            $display("FAIL drain_returns: got %0d beats %0d mismatched want 3 0", rcv_q.size(), mis); else n_pass++;
        cnt = 0;
        while (granted !== 1'b1 && cnt < 10) begin tick(); cnt++; end
        n_checks++; if (granted !== 1'b1) $display("FAIL regrant_after_drain: got %0b want 1", granted); else n_pass++;
        req = 0; exp_q.delete(); rcv_q.delete();
    endtask

    task automatic test_reset_midflight();
        pause = 0; exp_q.delete(); rcv_q.delete();
        rvld = 1; raddr = 16'h0100; tick();
        raddr = 16'h0101; tick();
        rvld = 0; rst = 1; tick(); smp();
        n_checks++; if ({granted, wrdy, rrdy, s_wen, s_ren, rdvld} !== 6'b0)
            $display("FAIL reset_mid_ctrl: got %b want 000000", {granted, wrdy, rrdy, s_wen, s_ren, rdvld}); else n_pass++;
        n_checks++; if (rdata_o !== '0 || s_addr !== '0)
            $display("FAIL reset_mid_data: got rdata %h addr %h want 0 0", rdata_o, s_addr); else n_pass++;
        tick(); rst = 0; exp_q.delete(); rcv_q.delete();
        repeat (10) tick();
        n_checks++; if (rcv_q.size() != 0 || rdvld !== 1'b0)
            $display("FAIL reset_no_stale: got %0d beats vld %0b want 0 0", rcv_q.size(), rdvld); else n_pass++;
    endtask

    task automatic test_random();
        int cnt, mis;
        req = 1; cnt = 0;
        while (granted !== 1'b1 && cnt < 10) begin tick(); cnt++; end
        n_checks++; if (granted !== 1'b1) $display("FAIL random_grant: got %0b want 1", granted); else n_pass++;
        req = 0; exp_q.delete(); rcv_q.delete();
        repeat (400) begin
            wvld  = ($urandom_range(2) == 0);
            waddr = AW'(16'h0040 + $urandom_range(7));
            wdata = {$urandom(), $urandom()};
            rvld  = $urandom_range(1) == 1;
            raddr = AW'(16'h0040 + $urandom_range(7));
            pause = ($urandom_range(3) == 0);
            tick();
        end
        wvld = 0; rvld = 0; pause = 0; cnt = 0;
        while (rcv_q.size() < exp_q.size() && cnt < 60) begin tick(); cnt++; end
        repeat (8) tick();
        n_checks++; if (exp_q.size() <= 20) $display("FAIL random_reads_issued: got %0d want >20", exp_q.size()); else n_pass++;
        n_checks++; if (rcv_q.size() != exp_q.size())
            $display("FAIL random_count: got %0d beats want %0d", rcv_q.size(), exp_q.size()); else n_pass++;
        mis = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rcv_q.size() && rcv_q[i] !== exp_q[i]) begin
                if (mis == 0) $display("FAIL random_data beat %0d: got %h want %h", i, rcv_q[i], exp_q[i]);
                mis++;
            end
        end
        n_checks++; if (mis != 0) $display("FAIL random_order: got %0d mismatched beats want 0", mis); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 256; a++) begin
            shadow[a]   = init_val(a);
            sram_mem[a] = init_val(a);
        end
        for (int i = 0; i < L; i++) rd_pipe[i] = '0;
        test_reset();
        test_grant();
        test_write_read();
        test_pause_backpressure();
        test_wr_rd_priority();
        test_release_drain();
        test_reset_midflight();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
